round_robin_mux_stream: RTL and testbench
=========================================

ROUND_ROBIN_MUX_STREAM -- requirements
Module: round_robin_mux_stream

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, number of input streams (legal range 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, data width per stream.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port in_valid  input  N_INPUTS  per-stream valid.
REQ-007 SHALL have port in_data  input  N_INPUTS*WIDTH  packed data; stream k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_ready  output  N_INPUTS  per-stream ready.
REQ-009 SHALL have port out_valid  output  1  output register holds a word.
REQ-010 SHALL have port out_data  output  WIDTH  selected word.
REQ-011 SHALL have port out_sel  output  SEL_W  index of the source stream; SEL_W = max(1, clog2(N_INPUTS)).
REQ-012 SHALL have port out_ready  input  1  downstream accepts.

Function
REQ-013 SHALL transfer on an input when in_valid[k] and in_ready[k] are both high at a rising clk, and on the output when out_valid and out_ready are both high.
REQ-014 SHALL compute "can_load" = !out_valid | out_ready; with can_load low, all in_ready SHALL be 0.
REQ-015 SHALL assert at most one in_ready bit per cycle, the round-robin grant among asserted in_valid bits, gated by can_load.
REQ-016 SHALL search for the grant starting at index (last_grant+1) mod N_INPUTS, ascending with wrap to 0 after N_INPUTS-1.
REQ-017 SHALL update last_grant only on a cycle where an input transfer occurs; otherwise it holds.
REQ-018 SHALL have a latency of 1 cycle: a word accepted at edge t appears on out_data/out_sel with out_valid=1 after edge t.
REQ-019 SHALL hold out_data, out_sel and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on a cycle with both an output transfer and an input transfer, replace the word with no bubble (full throughput, 1 word/cycle).
REQ-021 SHALL clear out_valid on an output transfer with no input transfer in the same cycle; out_data/out_sel then retain the last values.
REQ-022 SHALL keep in_ready free of any combinational dependence on in_data; in_ready MAY depend combinationally on in_valid and out_ready.
REQ-023 SHALL, with no in_valid asserted, grant nothing and leave last_grant unchanged.

Reset
REQ-024 SHALL, while rst=1, force out_valid=0, out_data=0, out_sel=0 and last_grant=N_INPUTS-1, so stream 0 has first priority.
REQ-025 SHALL discard any word held in the output register when rst asserts mid-operation; no input transfer occurs while rst=1 (in_ready=0).
REQ-026 SHALL resume normal arbitration on the first rising clk after rst deasserts.

Structure
REQ-027 SHALL take default N_INPUTS, WIDTH and a sel-width helper function from shared package mux_stream_pkg.
REQ-028 SHALL place the grant search in a combinational sub-module rr_arbiter (inputs: req, last_grant; output: one-hot grant plus index); all state stays in round_robin_mux_stream.
REQ-029 SHALL implement the data select as an N_INPUTS:1 mux indexed by the grant index, registered only in the output stage.

Verification
REQ-030 SHALL cover reset: after rst pulse, out_valid=0, out_data=0, out_sel=0, and in_valid=4'b1111 with out_ready=1 yields grants to streams 0,1,2,3,0 on consecutive cycles.
REQ-031 SHALL cover fairness: in_valid=4'b1010 held, out_ready=1 -> out_sel sequence 1,3,1,3 with one word per cycle.
REQ-032 SHALL cover backpressure: out_valid=1, out_data=8'hA5, out_ready=0 for 5 cycles -> in_ready=0 throughout, out_data stays 8'hA5, last_grant unchanged; next grant follows the pre-stall pointer.
REQ-033 SHALL cover the idle case: in_valid=0 with out_ready=1 -> out_valid drops to 0 after one cycle; later in_valid=4'b0100 -> out_sel=2 after 1 cycle.
REQ-034 SHALL cover reset mid-operation: rst asserted asynchronously (between edges) while out_valid=1 -> out_valid=0 immediately, and the first grant after release goes to stream 0.
REQ-035 SHALL cover wrap-around: N_INPUTS=3, last grant 2, in_valid=3'b011 -> next grant 0, then 1.

Source files
------------

// File: rtl/mux_stream_pkg.sv
// mux_stream_pkg: shared defaults and select-width helper for the stream mux
package mux_stream_pkg;
    localparam int DEF_N_INPUTS = 4;
    localparam int DEF_WIDTH = 8;
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant search starting after last_grant
module rr_arbiter #(
    parameter int N = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx
);
    int k;
    logic found;
    // scan ascending from last_grant+1 with wrap; first requester wins
    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        k = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(last_grant) + i) % N;
            if (!found && req[k]) begin
                found = 1'b1;
                grant[k] = 1'b1;
                idx = SW'(k);
            end
        end
    end
endmodule

// File: rtl/round_robin_mux_stream.sv
// round_robin_mux_stream: round-robin N:1 stream mux with a single registered output stage
module round_robin_mux_stream
    import mux_stream_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int WIDTH = DEF_WIDTH,
    localparam int SEL_W = sel_w(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_INPUTS-1:0]       in_valid,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    output logic [N_INPUTS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);
    logic [N_INPUTS-1:0] grant;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] last_grant;
    logic can_load;
    logic in_xfer;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(.N(N_INPUTS), .SW(SEL_W)) u_arb (
        .req(in_valid),
        .last_grant(last_grant),
        .grant(grant),
        .idx(idx)
    );

    // ready depends only on valids, output occupancy and out_ready; never on data
    always_comb begin
        can_load = !out_valid || out_ready;
        in_ready = (can_load && !rst) ? grant : '0;
        in_xfer = |in_ready;
        sel_data = in_data[int'(idx)*WIDTH +: WIDTH];
    end

    // output register and arbitration pointer; pointer moves only on an input transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_sel <= '0;
            last_grant <= SEL_W'(N_INPUTS - 1);
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data <= sel_data;
            out_sel <= idx;
            last_grant <= idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_round_robin_mux_stream.sv
// tb_round_robin_mux_stream: directed checks of arbitration, backpressure, idle, reset and wrap
module tb_round_robin_mux_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] in_valid = '0;
    logic [7:0] words [4];
    logic [31:0] in_data;
    logic [3:0] in_ready;
    logic out_valid;
    logic [7:0] out_data;
    logic [1:0] out_sel;
    logic out_ready = 1'b0;

    logic [2:0] in_valid3 = '0;
    logic [23:0] in_data3 = {8'h22, 8'h21, 8'h20};
    logic [2:0] in_ready3;
    logic out_valid3;
    logic [7:0] out_data3;
    logic [1:0] out_sel3;

    int checks = 0;
    int errors = 0;

    assign in_data = {words[3], words[2], words[1], words[0]};

    always #5 clk = ~clk;

    round_robin_mux_stream #(.N_INPUTS(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
    );

    round_robin_mux_stream #(.N_INPUTS(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3), .out_ready(1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] sel, input logic [7:0] data);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sel"}, 32'(out_sel), 32'(sel));
        chk({tag, "_data"}, 32'(out_data), 32'(data));
    endtask

    initial begin
        words[0] = 8'h10; words[1] = 8'h11; words[2] = 8'h12; words[3] = 8'h13;
        tick;
        tick;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sel", 32'(out_sel), 32'd0);
        rst = 1'b0;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("first_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk_out("all4", 2'(i % 4), 8'h10 + 8'(i % 4));
        end
        in_valid = 4'b1010;
        tick; chk_out("fair0", 2'd1, 8'h11);
        tick; chk_out("fair1", 2'd3, 8'h13);
        tick; chk_out("fair2", 2'd1, 8'h11);
        tick; chk_out("fair3", 2'd3, 8'h13);
        words[0] = 8'hA5;
        in_valid = 4'b0001;
        tick; chk_out("load_a5", 2'd0, 8'hA5);
        out_ready = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready", 32'(in_ready), 32'd0);
            tick;
            chk_out("stall", 2'd0, 8'hA5);
        end
        out_ready = 1'b1;
        #1;
        chk("post_stall_ready", 32'(in_ready), 32'b0010);
        tick; chk_out("post_stall", 2'd1, 8'h11);
        in_valid = 4'b0000;
        #1;
        chk("idle_ready", 32'(in_ready), 32'd0);
        tick;
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_sel_hold", 32'(out_sel), 32'd1);
        chk("idle_data_hold", 32'(out_data), 32'h11);
        tick;
        chk("idle_valid2", 32'(out_valid), 32'd0);
        in_valid = 4'b0100;
        tick; chk_out("idle_wake", 2'd2, 8'h12);
        out_ready = 1'b0;
        in_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick;
        chk("midrst_hold_valid", 32'(out_valid), 32'd0);
        chk("midrst_hold_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready), 32'b0001);
        tick; chk_out("rel_grant", 2'd0, 8'hA5);
        tick; chk_out("rel_next", 2'd1, 8'h11);
        in_valid3 = 3'b100;
        tick;
        chk("wrap_g2_sel", 32'(out_sel3), 32'd2);
        chk("wrap_g2_data", 32'(out_data3), 32'h22);
        in_valid3 = 3'b011;
        #1;
        chk("wrap_ready", 32'(in_ready3), 32'b001);
        tick;
        chk("wrap_g0_sel", 32'(out_sel3), 32'd0);
        chk("wrap_g0_data", 32'(out_data3), 32'h20);
        tick;
        chk("wrap_g1_sel", 32'(out_sel3), 32'd1);
        chk("wrap_g1_valid", 32'(out_valid3), 32'd1);
        tick;
        chk("wrap_g0b_sel", 32'(out_sel3), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
